// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encodings
// and the default operand width.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder.sv
// Existing 1-bit full-adder cell, purely combinational.
module fulladder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: captures operands on start, feeds LSB-first
// bit pairs through one full-adder cell over WIDTH cycles, recirculating the
// carry in a flop, and presents {cout, sum} with a one-cycle done pulse.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a - b.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int                 CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state, state_next;
  logic [WIDTH-1:0]   a_sr, b_sr, sum_sr;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               load, last;
  logic               fa_s, fa_cout;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1; cout=1 then means no borrow.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  fulladder u_fa (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Cin  (carry),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state decode plus the load/last strobes used by the datapath.
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    last       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == LAST_CNT) begin
          last       = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, serial shift, carry recirculation, result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b_load;
      carry  <= carry_load;
      cnt    <= '0;
      sum_sr <= '0;
    end else if (state == ST_RUN) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
      carry  <= fa_cout;
      if (last) begin
        // Counter returns to zero rather than stepping past WIDTH-1.
        cnt  <= '0;
        sum  <= {fa_s, sum_sr[WIDTH-1:1]};
        cout <= fa_cout;
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end
  end

  // Status flags decode the registered state, so they never overlap.
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule
